// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter.
//   shift_op_t    : operation encoding on the op port
//   shift_state_t : controller state encoding
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shifter_seq_step.sv
// shift_step: combinational single-step shifter.
//   i_acc    : word to shift
//   i_op     : SLL / SRL / SRA / ROL
//   i_k      : amount for this step (the parent keeps it <= STEP)
//   o_result : shifted word
// Rotate datapath only exists when SHIFTER_SEQ_ROTATE_EN is defined;
// otherwise op=11 behaves as SLL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int N       = 16,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic [N-1:0]       i_acc,
  input  shift_op_t          i_op,
  input  logic [SHAMT_W-1:0] i_k,
  output logic [N-1:0]       o_result
);

`ifdef SHIFTER_SEQ_ROTATE_EN
  // Right-shift amount for the wrapped-around bits; k=0 gives N, i.e. nothing.
  logic [SHAMT_W:0] w_back;
  assign w_back = (SHAMT_W+1)'(N) - {1'b0, i_k};
`endif

  always_comb begin
    o_result = i_acc << i_k;
    case (i_op)
      SH_SRL: o_result = i_acc >> i_k;
      SH_SRA: o_result = N'($signed(i_acc) >>> i_k);
`ifdef SHIFTER_SEQ_ROTATE_EN
      SH_ROL: o_result = (i_acc << i_k) | (i_acc >> w_back);
`endif
      default: o_result = i_acc << i_k;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle SLL/SRL/SRA (optional ROL) shifter, at most
// STEP bits per cycle, valid/ready handshake on both sides.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   op, shamt, data_in  : operation, amount (0..N-1), operand
//   out_valid/out_ready : result handshake (valid only in DONE)
//   data_out            : result, zero outside DONE
//   busy                : high in SHIFT or DONE
// Optional feature macro: SHIFTER_SEQ_ROTATE_EN (op=11 is ROL).
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready=1
// ST_SHIFT | shifting min(STEP,rem) bits per cycle
// ST_DONE  | result held on data_out until out_ready
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int N       = 16,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  shift_op_t          op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [N-1:0]       data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       data_out,
  output logic               busy
);

  // STEP may equal N, which does not fit in SHAMT_W bits.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  shift_state_t        r_state;
  logic [N-1:0]        r_acc;
  logic [SHAMT_W-1:0]  r_rem;
  shift_op_t           r_op;

  logic [SHAMT_W-1:0]  w_k;
  logic [N-1:0]        w_shifted;

  // rem <= N-1, so whenever rem > STEP the STEP value itself fits SHAMT_W.
  assign w_k = ({1'b0, r_rem} > STEP_W) ? STEP_W[SHAMT_W-1:0] : r_rem;

  shift_step #(
    .N       (N),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .i_acc    (r_acc),
    .i_op     (r_op),
    .i_k      (w_k),
    .o_result (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= SH_SLL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc   <= data_in;
            r_op    <= op;
            r_rem   <= shamt;
            r_state <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= r_rem - w_k;
          if (r_rem == w_k) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign data_out  = (r_state == ST_DONE) ? r_acc : '0;

endmodule
